// File: rtl/fifo_ram_bridge_pkg.sv
// Shared types, constants and helpers for the FIFO-to-RAM bridge.
package fifo_ram_bridge_pkg;

  // IDLE leaves after one cycle. FILL counts beats until READ_LAG words are
  // in the RAM. STREAM stays active until reset.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Port-2 read latency of the RAM, measured from address to data.
  localparam int RAM_RD_LATENCY = 1;

  // Unsigned subtract that wraps modulo 2**aw. The result is zero-extended
  // to 32 bits, and the caller truncates it to aw bits.
  function automatic logic [31:0] wrap_sub(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/bridge_valid_pipe.sv
// Valid-bit shift register of configurable depth, cleared synchronously.
module bridge_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic srst,
  input  logic shift_in,
  output logic shift_out
);

  logic [DEPTH-1:0] stages;

  // Shift one position per cycle. A clear drops every bit still in flight.
  always_ff @(posedge clk) begin
    if (srst) begin
      stages <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        stages[i] <= stages[i-1];
      end
      stages[0] <= shift_in;
    end
  end

  assign shift_out = stages[DEPTH-1];

endmodule

// File: rtl/fifo_ram_bridge.sv
// Moves FIFO beats into a dual-port RAM ring and streams the data back out.
// The read-back port follows the write pointer at a fixed lag.
module fifo_ram_bridge
  import fifo_ram_bridge_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int FIFO_LATENCY = 1,
  parameter int READ_LAG     = 3
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_re,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_waddr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic [ADDR_WIDTH-1:0] o_ram_raddr,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_wrap,
  output logic                  o_streaming
);

  localparam logic [ADDR_WIDTH-1:0] LAG     = ADDR_WIDTH'(READ_LAG);
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] wptr_next;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic                  beat;
  logic                  last_fill;
  logic                  issue;
  logic                  rd_issue;
  logic                  rd_capture;

  assign o_fifo_re = i_enable & ~i_fifo_empty & (state != ST_IDLE);

  // Every read strobe produces a beat exactly FIFO_LATENCY cycles later.
  bridge_valid_pipe #(
    .DEPTH(FIFO_LATENCY)
  ) u_fifo_pipe (
    .clk      (i_clk),
    .srst     (i_srst),
    .shift_in (o_fifo_re),
    .shift_out(beat)
  );

  assign wptr_next = wptr + 1'b1;
  assign last_fill = (state == ST_FILL) && ((fill_cnt + 1'b1) == LAG);
  assign issue     = beat && ((state == ST_STREAM) || last_fill);

  // Sequencer: leave IDLE at once, count fill beats, then stream until reset.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state       <= ST_IDLE;
      fill_cnt    <= '0;
      o_streaming <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_FILL;
        end
        ST_FILL: begin
          if (beat) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (last_fill) begin
              state       <= ST_STREAM;
              o_streaming <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          o_streaming <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write port and read address update together. The read address is taken
  // from the post-increment pointer, so the read that goes with the write to
  // address N targets address N+1-READ_LAG.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      wptr        <= '0;
      o_ram_we    <= 1'b0;
      o_ram_waddr <= '0;
      o_ram_wdata <= '0;
      o_ram_raddr <= '0;
      o_wrap      <= 1'b0;
      rd_issue    <= 1'b0;
    end else begin
      o_ram_we <= beat;
      o_wrap   <= beat && (wptr == PTR_MAX);
      rd_issue <= issue;
      if (beat) begin
        o_ram_waddr <= wptr;
        o_ram_wdata <= i_fifo_rdata;
        wptr        <= wptr_next;
      end
      if (issue) begin
        o_ram_raddr <= ADDR_WIDTH'(wrap_sub(32'(wptr_next), 32'(READ_LAG), ADDR_WIDTH));
      end
    end
  end

  // The read-issue flag is delayed by the RAM latency so that it lines up
  // with the port-2 data it qualifies.
  bridge_valid_pipe #(
    .DEPTH(RAM_RD_LATENCY)
  ) u_rd_pipe (
    .clk      (i_clk),
    .srst     (i_srst),
    .shift_in (rd_issue),
    .shift_out(rd_capture)
  );

  // Register the read-back data. o_data keeps its last value between valids.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= rd_capture;
      if (rd_capture) begin
        o_data <= i_ram_rdata;
      end
    end
  end

endmodule
